// File: rtl/div_pkg.sv
// Shared constants and FSM state type for the divider / re-multiply slice.
package div_pkg;

    localparam int unsigned DEFAULT_N = 4;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

endpackage

// File: rtl/seq_mul_add.sv
// Sequential shift-and-add multiplier: P = Quo * M (+ Rem), one bit per clock.
// Optional addend input Rem is enabled by defining SEQ_MUL_ADDEND_EN.
module seq_mul_add
    import div_pkg::*;
#(
    parameter int N = DEFAULT_N
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [N-1:0]     Quo,
    input  logic [N-1:0]     M,
`ifdef SEQ_MUL_ADDEND_EN
    input  logic [N-1:0]     Rem,
`endif
    output logic             busy,
    output logic             done,
    output logic [2*N-1:0]   P
);

    localparam int CW = $clog2(N + 1);

    state_t            state;
    state_t            state_next;
    logic [N-1:0]      mplier;
    logic [2*N-1:0]    mcand;
    logic [2*N-1:0]    acc;
    logic [2*N-1:0]    acc_next;
    logic [2*N-1:0]    acc_init;
    logic [CW-1:0]     cnt;
    logic              last;

`ifdef SEQ_MUL_ADDEND_EN
    assign acc_init = {{N{1'b0}}, Rem};
`else
    assign acc_init = '0;
`endif

    // Conditional add of the shifted multiplicand and final-iteration detect
    always_comb begin
        acc_next = acc;
        if (mplier[0]) begin
            acc_next = acc + mcand;
        end
        last = (cnt == CW'(N - 1));
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and handshake outputs
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = CALC;
                end
            end
            CALC: begin
                busy = 1'b1;
                if (last) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                busy       = 1'b1;
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath: operand capture, shift-and-add iterations, result register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mplier <= '0;
            mcand  <= '0;
            acc    <= '0;
            cnt    <= '0;
            P      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        mplier <= Quo;
                        mcand  <= {{N{1'b0}}, M};
                        acc    <= acc_init;
                        cnt    <= '0;
                    end
                end
                CALC: begin
                    acc    <= acc_next;
                    mplier <= mplier >> 1;
                    mcand  <= mcand << 1;
                    cnt    <= cnt + 1'b1;
                    // The last iteration's sum goes straight to P, saving a cycle
                    if (last) begin
                        P <= acc_next;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_mul_add.sv
// Directed self-checking bench for seq_mul_add (N=4); follows SEQ_MUL_ADDEND_EN.
module tb_seq_mul_add;

    localparam int N = 4;
`ifdef SEQ_MUL_ADDEND_EN
    localparam bit ADD = 1'b1;
`else
    localparam bit ADD = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [N-1:0]   quo;
    logic [N-1:0]   m;
    logic [N-1:0]   rem;
    logic           busy;
    logic           done;
    logic [2*N-1:0] p;

    int ncomp = 0;
    int nerr  = 0;
    logic [2*N-1:0] last_p;

    always #5 clk = ~clk;

    seq_mul_add #(.N(N)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .Quo   (quo),
        .M     (m),
`ifdef SEQ_MUL_ADDEND_EN
        .Rem   (rem),
`endif
        .busy  (busy),
        .done  (done),
        .P     (p)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncomp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0d expected %0d (quo=%0d m=%0d rem=%0d)",
                   tag, obs, exp, quo, m, rem);
        end
    endtask

    // Full transaction: start pulse, N CALC edges, DONE cycle, back to IDLE
    task automatic do_op(input string tag, input logic [N-1:0] q, input logic [N-1:0] mm,
                         input logic [N-1:0] r, input logic [2*N-1:0] exp);
        quo   = q;
        m     = mm;
        rem   = r;
        start = 1'b1;
        tick();
        start = 1'b0;
        quo   = '1;
        m     = '1;
        rem   = '1;
        check({tag, "_busy_c1"}, 32'(busy), 32'd1);
        check({tag, "_done_c1"}, 32'(done), 32'd0);
        check({tag, "_p_hold_c1"}, 32'(p), 32'(last_p));
        for (int i = 0; i < N - 1; i++) begin
            tick();
            check({tag, "_done_calc"}, 32'(done), 32'd0);
            check({tag, "_p_hold_calc"}, 32'(p), 32'(last_p));
        end
        tick();
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_busy_done"}, 32'(busy), 32'd1);
        check({tag, "_p"}, 32'(p), 32'(exp));
        tick();
        check({tag, "_done_after"}, 32'(done), 32'd0);
        check({tag, "_busy_after"}, 32'(busy), 32'd0);
        check({tag, "_p_held"}, 32'(p), 32'(exp));
        last_p = exp;
    endtask

    initial begin
        rst    = 1'b1;
        start  = 1'b0;
        quo    = '0;
        m      = '0;
        rem    = '0;
        last_p = '0;
        #2;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_p", 32'(p), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        tick();
        check("idle_busy", 32'(busy), 32'd0);

        do_op("div_check", 4'd1, 4'd12, 4'd3, ADD ? 8'd15 : 8'd12);
        do_op("max", 4'd15, 4'd15, 4'd14, ADD ? 8'd239 : 8'd225);
        do_op("zero_q", 4'd0, 4'd9, 4'd5, ADD ? 8'd5 : 8'd0);
        do_op("zero_m", 4'd11, 4'd0, 4'd7, ADD ? 8'd7 : 8'd0);
        do_op("mix", 4'd10, 4'd6, 4'd9, ADD ? 8'd69 : 8'd60);

        // Busy rejection: second start with new operands during CALC is ignored
        quo   = 4'd3;
        m     = 4'd5;
        rem   = 4'd2;
        start = 1'b1;
        tick();
        start = 1'b0;
        quo   = 4'd9;
        m     = 4'd9;
        tick();
        quo   = 4'd7;
        start = 1'b1;
        check("rej_busy", 32'(busy), 32'd1);
        tick();
        start = 1'b0;
        check("rej_done_c3", 32'(done), 32'd0);
        tick();
        check("rej_done_c4", 32'(done), 32'd0);
        tick();
        check("rej_done", 32'(done), 32'd1);
        check("rej_p", 32'(p), ADD ? 32'd17 : 32'd15);
        last_p = ADD ? 8'd17 : 8'd15;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("rej_no_second_done", 32'(done), 32'd0);
            check("rej_idle", 32'(busy), 32'd0);
        end

        // Reset in the third CALC cycle aborts with no done pulse
        quo   = 4'd9;
        m     = 4'd9;
        rem   = 4'd4;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        check("abort_busy_pre", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_p", 32'(p), 32'd0);
        tick();
        check("abort_p_hold", 32'(p), 32'd0);
        @(negedge clk);
        rst    = 1'b0;
        last_p = '0;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("abort_no_done", 32'(done), 32'd0);
        end
        do_op("post_rst", 4'd2, 4'd6, 4'd1, ADD ? 8'd13 : 8'd12);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nerr);
        $finish;
    end

    // Hard time limit so the run always ends
    initial begin
        #100000;
        $display("FAIL timeout: observed no finish, required finish before 100000");
        $fatal(1, "timeout");
    end

endmodule
